// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM state type and the store lane/merge helper for data_mem_sync.
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL : i_size encodings
//   state_t                        : {CLEAR, IDLE}
//   store_lanes()                  : byte enables and lane-replicated store data for a size/lane pair
package dmem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic {CLEAR, IDLE} state_t;

   typedef struct packed {
      logic [3:0]  be;
      logic [31:0] data;
   } store_t;

   // Data is replicated across all lanes so that the enabled lanes pick up the right bytes
   // without a shifter; only lanes with be set are written.
   function automatic store_t store_lanes(input logic [1:0] size, input logic [1:0] lane, input logic [31:0] wdata);
      store_lanes.be   = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      store_lanes.data = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
   endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane steering for data_mem_sync.
//   size  in  2  access size (dmem_pkg encodings)
//   lane  in  2  byte offset within the word (addr[1:0])
//   uns   in  1  zero-extend loads when 1, sign-extend when 0
//   wdata in  32 right-aligned store data
//   rword in  32 addressed memory word
//   rdata out 32 right-aligned, extended load data
//   be    out 4  store byte enables
//   wword out 32 lane-replicated store data
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wword
);
   logic [7:0]  b;
   logic [15:0] h;
   store_t      st;

   always_comb begin
      b     = rword[8*lane +: 8];
      h     = lane[1] ? rword[31:16] : rword[15:0];
      rdata = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} : size == SZ_HALF ? {{16{~uns & h[15]}}, h} : rword;
      st    = store_lanes(size, lane, wdata);
   end

   assign be    = st.be;
   assign wword = st.data;
endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: synchronous byte-addressable data memory with valid/ready requests and registered reads.
//   i_clk, i_rst_n           clock, async active-low reset
//   i_valid / o_ready        request handshake; o_ready high only in IDLE
//   i_memread / i_memwrite   load / store select (exactly one must be set)
//   i_address, i_size        byte address, 00 byte / 01 half / 10 word
//   i_unsigned, i_write_data load extension select, right-aligned store data
//   o_rvalid, o_read_data    one-cycle response pulse and load result (0 otherwise)
//   o_err                    range / alignment / size / command error, qualified by o_rvalid
//   Macro DMEM_ACCESS_CNT_EN adds saturating counters o_rd_cnt, o_wr_cnt, o_err_cnt.
module data_mem_sync
   import dmem_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DEPTH      = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_3000,
   parameter bit                CLR_ON_RST = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_memread,
   input  logic              i_memwrite,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [31:0]       i_write_data,
   output logic              o_rvalid,
   output logic [31:0]       o_read_data,
   output logic              o_err
`ifdef DMEM_ACCESS_CNT_EN
   ,
   output logic [31:0]       o_rd_cnt,
   output logic [31:0]       o_wr_cnt,
   output logic [31:0]       o_err_cnt
`endif
);
   localparam int                IW   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

   state_t            state;
   logic [IW-1:0]     clr_idx;
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] off;
   logic [IW-1:0]     idx;
   logic              accept, bad;
   logic [31:0]       rdata, wword;
   logic [3:0]        be;

   assign accept = i_valid && o_ready;
   assign off    = i_address - BASE_ADDR;
   assign idx    = off[IW+1:2];
   // The lower-bound compare stops the subtraction from wrapping addresses below BASE_ADDR into range.
   assign bad    = i_address < BASE_ADDR || off >= SPAN || i_size == SZ_ILL || i_memread == i_memwrite
                || (i_size == SZ_HALF && i_address[0]) || (i_size == SZ_WORD && i_address[1:0] != 2'b00);

   dmem_align u_align (
      .size  (i_size),
      .lane  (i_address[1:0]),
      .uns   (i_unsigned),
      .wdata (i_write_data),
      .rword (mem[idx]),
      .rdata (rdata),
      .be    (be),
      .wword (wword)
   );

   // Array has no reset; zeroing is done by the CLEAR sequence instead.
   always_ff @(posedge i_clk)
      if (state == CLEAR)
         mem[clr_idx] <= '0;
      else if (accept && !bad && i_memwrite)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state       <= CLR_ON_RST ? CLEAR : IDLE;
         clr_idx     <= '0;
         o_ready     <= 1'b0;
         o_rvalid    <= 1'b0;
         o_read_data <= '0;
         o_err       <= 1'b0;
      end else begin
         o_rvalid    <= accept;
         o_err       <= accept && bad;
         o_read_data <= accept && !bad && i_memread ? rdata : '0;
         if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            state   <= &clr_idx ? IDLE : CLEAR;
            o_ready <= &clr_idx;
         end else
            o_ready <= 1'b1;
      end

`ifdef DMEM_ACCESS_CNT_EN
   // accept is only possible in IDLE, so CLEAR never counts.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_rd_cnt  <= '0;
         o_wr_cnt  <= '0;
         o_err_cnt <= '0;
      end else if (accept) begin
         if (bad && ~&o_err_cnt) o_err_cnt <= o_err_cnt + 1'b1;
         if (!bad && i_memread && ~&o_rd_cnt) o_rd_cnt <= o_rd_cnt + 1'b1;
         if (!bad && i_memwrite && ~&o_wr_cnt) o_wr_cnt <= o_wr_cnt + 1'b1;
      end
`endif
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: directed self-checking bench for data_mem_sync (DEPTH=16, BASE 0x3000, clear on reset).
module tb_data_mem_sync;
   localparam logic [31:0] BASE = 32'h0000_3000;

   logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ready;
   logic        memread = 1'b0, memwrite = 1'b0, uns = 1'b0;
   logic [31:0] address = '0, wdata = '0, rdata;
   logic [1:0]  size = 2'b10;
   logic        rvalid, err;
   int          n_cmp = 0, n_bad = 0, n, rv;
`ifdef DMEM_ACCESS_CNT_EN
   logic [31:0] rd_cnt, wr_cnt, err_cnt;
`endif

   data_mem_sync #(.DEPTH(16)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (valid),
      .o_ready      (ready),
      .i_memread    (memread),
      .i_memwrite   (memwrite),
      .i_address    (address),
      .i_size       (size),
      .i_unsigned   (uns),
      .i_write_data (wdata),
      .o_rvalid     (rvalid),
      .o_read_data  (rdata),
      .o_err        (err)
`ifdef DMEM_ACCESS_CNT_EN
      ,
      .o_rd_cnt     (rd_cnt),
      .o_wr_cnt     (wr_cnt),
      .o_err_cnt    (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic wait_clear(output int cycles, output int pulses);
      cycles = 0;
      pulses = 0;
      while (!ready && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (rvalid) pulses++;
      end
      valid = 1'b0;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
      memread  = rd;
      memwrite = wr;
      address  = a;
      size     = sz;
      uns      = u;
      wdata    = wd;
      valid    = 1'b1;
   endtask

   task automatic acc(input string tag, input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input logic [31:0] exp, input logic e);
      @(negedge clk);
      chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
      drive(rd, wr, a, sz, u, wd);
      @(negedge clk);
      valid = 1'b0;
      chk({tag, ".rvalid"}, {31'd0, rvalid}, 32'd1);
      chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
      chk({tag, ".data"}, rdata, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst.ready", {31'd0, ready}, 32'd0);
      chk("rst.rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst.data", rdata, 32'd0);
      chk("rst.err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      wait_clear(n, rv);
      chk("clr_cycles", n, 32'd16);

      acc("st_w3", 0, 1, BASE + 32'h0C, 2'b10, 0, 32'hAAAA_5555, 32'd0, 0);
      acc("st_w12", 0, 1, BASE + 32'h30, 2'b10, 0, 32'hAAAA_5555, 32'd0, 0);
      acc("ld_w12", 1, 0, BASE + 32'h30, 2'b10, 0, 32'd0, 32'hAAAA_5555, 0);

      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      chk("midclr.ready", {31'd0, ready}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      drive(0, 1, BASE + 32'h14, 2'b10, 0, 32'h1234_5678);
      rst_n = 1'b1;
      wait_clear(n, rv);
      chk("reclr_cycles", n, 32'd16);
      chk("clr_no_rvalid", rv, 32'd0);
      for (int i = 0; i < 16; i++)
         acc($sformatf("zero%0d", i), 1, 0, BASE + 32'(4 * i), 2'b10, 0, 32'd0, 32'd0, 0);

      acc("st_beef", 0, 1, BASE + 32'h10, 2'b10, 0, 32'hDEAD_BEEF, 32'd0, 0);
      acc("sb_80", 0, 1, BASE + 32'h11, 2'b00, 0, 32'h1234_5680, 32'd0, 0);
      acc("lw_10", 1, 0, BASE + 32'h10, 2'b10, 1, 32'd0, 32'hDEAD_80EF, 0);
      acc("lb_11", 1, 0, BASE + 32'h11, 2'b00, 0, 32'd0, 32'hFFFF_FF80, 0);
      acc("lbu_11", 1, 0, BASE + 32'h11, 2'b00, 1, 32'd0, 32'h0000_0080, 0);
      acc("lb_13", 1, 0, BASE + 32'h13, 2'b00, 1, 32'd0, 32'h0000_00DE, 0);

      acc("st_w20", 0, 1, BASE + 32'h20, 2'b10, 0, 32'h1122_3344, 32'd0, 0);
      acc("sh_8001", 0, 1, BASE + 32'h22, 2'b01, 0, 32'hFFFF_8001, 32'd0, 0);
      acc("lh_22", 1, 0, BASE + 32'h22, 2'b01, 0, 32'd0, 32'hFFFF_8001, 0);
      acc("lhu_22", 1, 0, BASE + 32'h22, 2'b01, 1, 32'd0, 32'h0000_8001, 0);
      acc("lw_20", 1, 0, BASE + 32'h20, 2'b10, 0, 32'd0, 32'h8001_3344, 0);
      acc("lh_20", 1, 0, BASE + 32'h20, 2'b01, 0, 32'd0, 32'h0000_3344, 0);

      acc("e_lw_mis", 1, 0, BASE + 32'h02, 2'b10, 0, 32'd0, 32'd0, 1);
      acc("e_lh_mis", 1, 0, BASE + 32'h01, 2'b01, 0, 32'd0, 32'd0, 1);
      acc("e_below", 1, 0, BASE - 32'd4, 2'b10, 0, 32'd0, 32'd0, 1);
      acc("e_above", 1, 0, BASE + 32'h40, 2'b00, 0, 32'd0, 32'd0, 1);
      acc("e_size", 1, 0, BASE + 32'h10, 2'b11, 0, 32'd0, 32'd0, 1);
      acc("e_rw", 1, 1, BASE + 32'h10, 2'b10, 0, 32'd0, 32'd0, 1);
      acc("e_none", 0, 0, BASE + 32'h10, 2'b10, 0, 32'd0, 32'd0, 1);
      acc("e_sw_mis", 0, 1, BASE + 32'h12, 2'b10, 0, 32'hFFFF_FFFF, 32'd0, 1);
      acc("e_sw_above", 0, 1, BASE + 32'h40, 2'b10, 0, 32'hFFFF_FFFF, 32'd0, 1);
      acc("lw_10_kept", 1, 0, BASE + 32'h10, 2'b10, 0, 32'd0, 32'hDEAD_80EF, 0);
      acc("lw_0_kept", 1, 0, BASE, 2'b10, 0, 32'd0, 32'd0, 0);
      acc("sw_last", 0, 1, BASE + 32'h3C, 2'b10, 0, 32'hCAFE_F00D, 32'd0, 0);
      acc("lw_last", 1, 0, BASE + 32'h3C, 2'b10, 0, 32'd0, 32'hCAFE_F00D, 0);

      @(negedge clk);
      drive(0, 1, BASE + 32'h30, 2'b10, 0, 32'h0BAD_CAFE);
      @(negedge clk);
      drive(1, 0, BASE + 32'h30, 2'b10, 0, 32'd0);
      chk("b2b.st_rvalid", {31'd0, rvalid}, 32'd1);
      chk("b2b.st_data", rdata, 32'd0);
      @(negedge clk);
      valid = 1'b0;
      chk("b2b.ld_rvalid", {31'd0, rvalid}, 32'd1);
      chk("b2b.ld_data", rdata, 32'h0BAD_CAFE);
      @(negedge clk);
      chk("b2b.idle_rvalid", {31'd0, rvalid}, 32'd0);
      chk("b2b.idle_data", rdata, 32'd0);

`ifdef DMEM_ACCESS_CNT_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("cnt.rst", rd_cnt | wr_cnt | err_cnt, 32'd0);
      rst_n = 1'b1;
      wait_clear(n, rv);
      chk("cnt.clr", rd_cnt | wr_cnt | err_cnt, 32'd0);
      acc("c_ld0", 1, 0, BASE, 2'b10, 0, 32'd0, 32'd0, 0);
      acc("c_st0", 0, 1, BASE + 32'h04, 2'b00, 0, 32'h0000_0077, 32'd0, 0);
      acc("c_ld1", 1, 0, BASE + 32'h04, 2'b00, 1, 32'd0, 32'h0000_0077, 0);
      acc("c_err", 1, 0, BASE + 32'h01, 2'b10, 0, 32'd0, 32'd0, 1);
      acc("c_st1", 0, 1, BASE + 32'h08, 2'b10, 0, 32'h5, 32'd0, 0);
      acc("c_ld2", 1, 0, BASE + 32'h08, 2'b10, 0, 32'd0, 32'h5, 0);
      chk("cnt.rd", rd_cnt, 32'd3);
      chk("cnt.wr", wr_cnt, 32'd2);
      chk("cnt.err", err_cnt, 32'd1);
      @(negedge clk);
      force dut.o_rd_cnt = 32'hFFFF_FFFF;
      #1 release dut.o_rd_cnt;
      acc("c_ld_sat", 1, 0, BASE + 32'h08, 2'b10, 0, 32'd0, 32'h5, 0);
      chk("cnt.rd_sat", rd_cnt, 32'hFFFF_FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
